// File: rtl/display_scanner_pkg.sv
// Shared definitions for the 4-digit 7-segment scan driver: digit count,
// anode patterns, FSM state encoding and small helper functions.
package display_scanner_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] AN_ALL_OFF = 4'b1111;
    localparam logic [1:0] IDX_LAST   = 2'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Active-low one-hot anode drive for digit position idx.
    function automatic logic [3:0] an_onehot(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Nibble of digit position idx within a 4-digit value.
    function automatic logic [3:0] nibble_sel(input logic [15:0] v, input logic [1:0] idx);
        logic [3:0] n;
        case (idx)
            2'd0:    n = v[3:0];
            2'd1:    n = v[7:4];
            2'd2:    n = v[11:8];
            default: n = v[15:12];
        endcase
        return n;
    endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Host/board-side signal bundle of the scan driver. The master drives the
// value, load strobe and display controls; the slave (the scanner) drives the
// digit nibble, anode pattern and frame pulse.
interface display_scanner_if;

    logic [15:0] value_i;
    logic        load_i;
    logic [3:0]  en_i;
    logic        lzb_i;
    logic [3:0]  digit_o;
    logic [3:0]  an_n_o;
    logic        frame_o;

    modport master (
        output value_i,
        output load_i,
        output en_i,
        output lzb_i,
        input  digit_o,
        input  an_n_o,
        input  frame_o
    );

    modport slave (
        input  value_i,
        input  load_i,
        input  en_i,
        input  lzb_i,
        output digit_o,
        output an_n_o,
        output frame_o
    );

endinterface

// File: rtl/display_scanner_scan_tick_gen.sv
// Slot timer for the scan driver. Counts 0..REFRESH_DIV-1 per digit slot.
//   slot_end : current cycle is the last one of the slot
//   end_nxt  : the cycle after this edge will be the last one of a slot
//   in_blank : the cycle after this edge falls inside the blanking window
// The look-ahead flags let the top register its outputs in step with the count.
module scan_tick_gen #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_end,
    output logic end_nxt,
    output logic in_blank
);

    localparam int                CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] slot_cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Terminal-count detection and the position the counter moves to next.
    always_comb begin
        slot_end = (slot_cnt == LAST);
        cnt_nxt  = slot_end ? '0 : slot_cnt + CNT_W'(1);
        end_nxt  = (cnt_nxt == LAST);
        in_blank = (32'(cnt_nxt) < 32'(BLANK_CYC));
    end

    // Slot position counter, wraps at the end of every slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed scan driver for a 4-digit common-anode 7-segment display.
// Steps through the digits one slot at a time, blanking all anodes at the start
// of each slot, and presents the digit nibble plus its active-low anode select.
// New values are double-buffered and only swapped in at the frame boundary.
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic              clk,
    input  logic              rst_n,
    display_scanner_if.slave  bus
);

    logic        slot_end;
    logic        end_nxt;
    logic        in_blank;

    logic [1:0]  idx;
    logic [1:0]  idx_nxt;
    scan_state_e state;
    scan_state_e state_nxt;

    logic [15:0] active;
    logic [15:0] active_nxt;
    logic [15:0] pending;
    logic        pend_v;
    logic        boundary;

    logic [3:0]  digit_nxt;
    logic [3:0]  an_nxt;
    logic        frame_nxt;

    // A digit is lit when enabled and not suppressed as a leading zero.
    // Digit 0 is never suppressed so a zero value still shows one "0".
    function automatic logic digit_lit(input logic [15:0] v, input logic [1:0] i,
                                       input logic [3:0] en, input logic lzb);
        logic upper_zero;
        case (i)
            2'd1:    upper_zero = (v[15:4]  == 12'h000);
            2'd2:    upper_zero = (v[15:8]  == 8'h00);
            2'd3:    upper_zero = (v[15:12] == 4'h0);
            default: upper_zero = 1'b0;
        endcase
        return en[i] && !(lzb && upper_zero);
    endfunction

    scan_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .slot_end (slot_end),
        .end_nxt  (end_nxt),
        .in_blank (in_blank)
    );

    // Next digit index, buffer swap at the frame boundary, FSM and output values.
    always_comb begin
        idx_nxt    = idx;
        active_nxt = active;
        state_nxt  = state;
        boundary   = slot_end && (idx == IDX_LAST);

        if (slot_end) begin
            idx_nxt = idx + 2'd1;
        end

        // A load landing on the boundary cycle bypasses the pending buffer.
        if (boundary) begin
            if (bus.load_i) begin
                active_nxt = bus.value_i;
            end else if (pend_v) begin
                active_nxt = pending;
            end
        end

        case (state)
            ST_BLANK: if (!in_blank) state_nxt = ST_SHOW;
            ST_SHOW:  if (in_blank)  state_nxt = ST_BLANK;
            default:  state_nxt = ST_BLANK;
        endcase

        digit_nxt = nibble_sel(active_nxt, idx_nxt);
        an_nxt    = AN_ALL_OFF;
        if ((state_nxt == ST_SHOW) && digit_lit(active_nxt, idx_nxt, bus.en_i, bus.lzb_i)) begin
            an_nxt = an_onehot(idx_nxt);
        end
        frame_nxt = end_nxt && (idx_nxt == IDX_LAST);
    end

    // Scan position and FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= 2'd0;
            state <= ST_BLANK;
        end else begin
            idx   <= idx_nxt;
            state <= state_nxt;
        end
    end

    // Double buffer: the last load of a frame wins, active changes only at the boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 16'h0000;
            pending <= 16'h0000;
            pend_v  <= 1'b0;
        end else begin
            active <= active_nxt;
            if (boundary) begin
                pend_v <= 1'b0;
            end else if (bus.load_i) begin
                pending <= bus.value_i;
                pend_v  <= 1'b1;
            end
        end
    end

    // Registered board-facing outputs, aligned with the scan position they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.digit_o <= 4'h0;
            bus.an_n_o  <= AN_ALL_OFF;
            bus.frame_o <= 1'b0;
        end else begin
            bus.digit_o <= digit_nxt;
            bus.an_n_o  <= an_nxt;
            bus.frame_o <= frame_nxt;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with an 8-cycle slot and 2 blank cycles.
module tb_display_scanner;

    localparam int RDIV  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * RDIV;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    display_scanner_if bus ();

    display_scanner #(
        .REFRESH_DIV (RDIV),
        .BLANK_CYC   (BLANK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until frame_o is seen high at a falling edge.
    task automatic wait_frame(input string tag);
        bit found;
        found = 1'b0;
        for (int n = 0; n < FRAME + 8; n++) begin
            @(negedge clk);
            if (bus.frame_o === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s frame_o observed=0 expected=1 within %0d cycles", tag, FRAME + 8);
        end
    endtask

    // Check one full frame cycle by cycle. With now=0 the first sample is at the
    // next falling edge; with now=1 it is taken immediately.
    task automatic check_frame(input string tag, input bit now,
                               input logic [3:0] a0, input logic [3:0] a1,
                               input logic [3:0] a2, input logic [3:0] a3,
                               input logic [3:0] d0, input logic [3:0] d1,
                               input logic [3:0] d2, input logic [3:0] d3);
        logic [3:0] ea [4];
        logic [3:0] ed [4];
        logic [3:0] exp_an;
        ea[0] = a0; ea[1] = a1; ea[2] = a2; ea[3] = a3;
        ed[0] = d0; ed[1] = d1; ed[2] = d2; ed[3] = d3;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0 || !now) @(negedge clk);
            exp_an = ((i % RDIV) < BLANK) ? 4'b1111 : ea[i / RDIV];
            chk($sformatf("%s an s%0d c%0d", tag, i / RDIV, i % RDIV), 8'(bus.an_n_o), 8'(exp_an));
            chk($sformatf("%s digit s%0d c%0d", tag, i / RDIV, i % RDIV), 8'(bus.digit_o), 8'(ed[i / RDIV]));
            chk($sformatf("%s frame c%0d", tag, i), 8'(bus.frame_o), 8'((i == FRAME - 1) ? 1 : 0));
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.value_i = 16'h0000;
        bus.load_i  = 1'b0;
        bus.en_i    = 4'hF;
        bus.lzb_i   = 1'b0;

        // Held in reset with the clock running.
        repeat (2) @(negedge clk);
        chk("reset an", 8'(bus.an_n_o), 8'h0F);
        chk("reset digit", 8'(bus.digit_o), 8'h00);
        chk("reset frame", 8'(bus.frame_o), 8'h00);

        // Release and queue 1234; it appears in the frame after the first frame_o.
        #1;
        rst_n       = 1'b1;
        bus.value_i = 16'h1234;
        bus.load_i  = 1'b1;
        @(posedge clk);
        #1 bus.load_i = 1'b0;
        wait_frame("first frame_o");
        check_frame("v1234", 1'b0, 4'b1110, 4'b1101, 4'b1011, 4'b0111,
                    4'h4, 4'h3, 4'h2, 4'h1);

        // Boundary-cycle load with leading-zero blanking.
        bus.lzb_i   = 1'b1;
        bus.value_i = 16'h0050;
        bus.load_i  = 1'b1;
        @(posedge clk);
        #1 bus.load_i = 1'b0;
        check_frame("lzb0050", 1'b0, 4'b1110, 4'b1101, 4'b1111, 4'b1111,
                    4'h0, 4'h5, 4'h0, 4'h0);

        bus.value_i = 16'h0000;
        bus.load_i  = 1'b1;
        @(posedge clk);
        #1 bus.load_i = 1'b0;
        check_frame("lzb0000", 1'b0, 4'b1110, 4'b1111, 4'b1111, 4'b1111,
                    4'h0, 4'h0, 4'h0, 4'h0);

        // Two loads inside one frame: only the last is shown next frame.
        bus.lzb_i = 1'b0;
        repeat (3) @(negedge clk);
        bus.value_i = 16'hAAAA;
        bus.load_i  = 1'b1;
        @(negedge clk);
        bus.load_i  = 1'b0;
        repeat (3) @(negedge clk);
        bus.value_i = 16'h5678;
        bus.load_i  = 1'b1;
        @(negedge clk);
        bus.load_i  = 1'b0;
        wait_frame("frame after double load");
        check_frame("v5678", 1'b0, 4'b1110, 4'b1101, 4'b1011, 4'b0111,
                    4'h8, 4'h7, 4'h6, 4'h5);

        // Enable mask 0101 with a boundary load of 1234.
        bus.en_i    = 4'b0101;
        bus.value_i = 16'h1234;
        bus.load_i  = 1'b1;
        @(posedge clk);
        #1 bus.load_i = 1'b0;
        check_frame("en0101", 1'b0, 4'b1110, 4'b1111, 4'b1011, 4'b1111,
                    4'h4, 4'h3, 4'h2, 4'h1);

        // Asynchronous reset in the middle of a SHOW cycle, no clock edge needed.
        repeat (4) @(negedge clk);
        chk("pre-reset an", 8'(bus.an_n_o), 8'h0E);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset an", 8'(bus.an_n_o), 8'h0F);
        chk("async reset digit", 8'(bus.digit_o), 8'h00);
        chk("async reset frame", 8'(bus.frame_o), 8'h00);
        #1 rst_n = 1'b1;
        #1;
        check_frame("after reset", 1'b1, 4'b1110, 4'b1111, 4'b1011, 4'b1111,
                    4'h0, 4'h0, 4'h0, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
